// File: rtl/matrix_data_memory.sv
// matrix_data_memory
// Word-addressed data memory for the MIPS core's matrix workloads.
// Three DIM x DIM regions live at fixed byte bases: A and B hold the
// operands, C holds the result. The CPU side offers a registered load
// and a synchronous store. A small dump engine streams C out, row-major,
// over a valid/ready port. C is frozen against CPU stores while a dump
// is running, so the streamed words cannot change underneath the sink.

module matrix_data_memory #(
   parameter int unsigned       DATA_W = 32,
   parameter int unsigned       ADDR_W = 32,
   parameter int unsigned       DIM    = 3,
   parameter logic [ADDR_W-1:0] A_BASE = 32'h0000_0200,
   parameter logic [ADDR_W-1:0] B_BASE = 32'h0000_0300,
   parameter logic [ADDR_W-1:0] C_BASE = 32'h0000_0100,
   localparam int unsigned      N      = DIM * DIM,
   localparam int unsigned      IDX_W  = (N > 1) ? $clog2(N) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid,
   output logic              addr_err,
   output logic              wr_blocked,
   input  logic              dump_start,
   output logic              dump_busy,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [DATA_W-1:0] dump_data,
   output logic [IDX_W-1:0]  dump_index,
   output logic              dump_done
);

   // Size of one region in bytes, and the index of the last element.
   localparam logic [ADDR_W-1:0] REGION_BYTES = ADDR_W'(4 * N);
   localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(N - 1);
   localparam logic [IDX_W-1:0]  IDX_ONE      = IDX_W'(1);

   typedef enum logic {
      IDLE,
      STREAM
   } dump_state_t;

   dump_state_t state;

   // Region storage, one word per element.
   logic [DATA_W-1:0] mem_a [N];
   logic [DATA_W-1:0] mem_b [N];
   logic [DATA_W-1:0] mem_c [N];

   // Decode: offset from each base; an offset below the region size
   // means a hit (addresses below the base wrap to huge offsets).
   logic [ADDR_W-1:0] off_a;
   logic [ADDR_W-1:0] off_b;
   logic [ADDR_W-1:0] off_c;
   logic              aligned;
   logic              hit_a;
   logic              hit_b;
   logic              hit_c;
   logic              legal;
   logic [IDX_W-1:0]  idx_a;
   logic [IDX_W-1:0]  idx_b;
   logic [IDX_W-1:0]  idx_c;

   assign off_a   = address - A_BASE;
   assign off_b   = address - B_BASE;
   assign off_c   = address - C_BASE;
   assign aligned = (address[1:0] == 2'b00);
   assign hit_a   = aligned && (off_a < REGION_BYTES);
   assign hit_b   = aligned && (off_b < REGION_BYTES);
   assign hit_c   = aligned && (off_c < REGION_BYTES);
   assign legal   = hit_a || hit_b || hit_c;
   assign idx_a   = off_a[IDX_W+1:2];
   assign idx_b   = off_b[IDX_W+1:2];
   assign idx_c   = off_c[IDX_W+1:2];

   // Operation classification; both strobes together is neither a load
   // nor a store and is reported as an error.
   logic load_op;
   logic store_op;
   logic both_op;
   logic we_a;
   logic we_b;
   logic we_c;
   logic c_blocked;

   assign load_op   = mem_read && !mem_write;
   assign store_op  = mem_write && !mem_read;
   assign both_op   = mem_read && mem_write;
   assign we_a      = store_op && hit_a;
   assign we_b      = store_op && hit_b;
   assign c_blocked = store_op && hit_c && dump_busy;
   assign we_c      = store_op && hit_c && !dump_busy;

   // Select the addressed word for a load; illegal addresses read as zero.
   logic [DATA_W-1:0] rd_word;

   always_comb begin
      rd_word = '0;
      if (hit_a) begin
         rd_word = mem_a[idx_a];
      end else if (hit_b) begin
         rd_word = mem_b[idx_b];
      end else if (hit_c) begin
         rd_word = mem_c[idx_c];
      end
   end

   // Region A: reset to 1..N, written by legal CPU stores.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(N); i++) begin
            mem_a[i] <= DATA_W'(i + 1);
         end
      end else if (we_a) begin
         mem_a[idx_a] <= data_in;
      end
   end

   // Region B: reset to the identity matrix, written by legal CPU stores.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(N); i++) begin
            mem_b[i] <= ((i % (int'(DIM) + 1)) == 0) ? DATA_W'(1) : '0;
         end
      end else if (we_b) begin
         mem_b[idx_b] <= data_in;
      end
   end

   // Region C: reset to zero, written only while no dump is streaming it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(N); i++) begin
            mem_c[i] <= '0;
         end
      end else if (we_c) begin
         mem_c[idx_c] <= data_in;
      end
   end

   // CPU response: registered load data (held between loads) and status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out   <= '0;
         rd_valid   <= 1'b0;
         addr_err   <= 1'b0;
         wr_blocked <= 1'b0;
      end else begin
         rd_valid   <= load_op;
         addr_err   <= both_op || ((load_op || store_op) && !legal);
         wr_blocked <= c_blocked;
         if (load_op) begin
            data_out <= rd_word;
         end
      end
   end

   // Dump engine: walks C row-major, advancing one element per accepted word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         dump_busy  <= 1'b0;
         dump_valid <= 1'b0;
         dump_index <= '0;
         dump_done  <= 1'b0;
      end else begin
         dump_done <= 1'b0;
         case (state)
            IDLE: begin
               if (dump_start) begin
                  state      <= STREAM;
                  dump_busy  <= 1'b1;
                  dump_valid <= 1'b1;
                  dump_index <= '0;
               end
            end
            STREAM: begin
               if (dump_valid && dump_ready) begin
                  if (dump_index == LAST_IDX) begin
                     state      <= IDLE;
                     dump_busy  <= 1'b0;
                     dump_valid <= 1'b0;
                     dump_index <= '0;
                     dump_done  <= 1'b1;
                  end else begin
                     dump_index <= dump_index + IDX_ONE;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // C cannot change while streaming, so a direct array read is stable.
   assign dump_data = mem_c[dump_index];

endmodule

// File: tb/tb_matrix_data_memory.sv
// tb_matrix_data_memory
// Scoreboard bench: the driver updates a behavioural model and queues the
// expected CPU responses and dump words; a monitor compares them as the
// memory presents them.

module tb_matrix_data_memory;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DIM    = 3;
   localparam int unsigned N      = DIM * DIM;
   localparam int unsigned IDX_W  = 4;
   localparam logic [31:0] A_BASE = 32'h0000_0200;
   localparam logic [31:0] B_BASE = 32'h0000_0300;
   localparam logic [31:0] C_BASE = 32'h0000_0100;

   logic              clk;
   logic              rst_n;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              rd_valid;
   logic              addr_err;
   logic              wr_blocked;
   logic              dump_start;
   logic              dump_busy;
   logic              dump_valid;
   logic              dump_ready;
   logic [DATA_W-1:0] dump_data;
   logic [IDX_W-1:0]  dump_index;
   logic              dump_done;

   typedef struct {
      logic        rv;
      logic        ae;
      logic        wb;
      logic [31:0] data;
   } cpu_exp_t;

   typedef struct {
      int          idx;
      logic [31:0] data;
   } dump_exp_t;

   cpu_exp_t  cpu_q[$];
   dump_exp_t dump_q[$];

   int tests_run    = 0;
   int tests_failed = 0;

   logic [31:0] ref_a [N];
   logic [31:0] ref_b [N];
   logic [31:0] ref_c [N];
   logic [31:0] ref_last;
   bit          ref_busy;
   int          ref_left;
   bit          done_due;

   matrix_data_memory #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .DIM   (DIM),
      .A_BASE(A_BASE),
      .B_BASE(B_BASE),
      .C_BASE(C_BASE)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .address   (address),
      .data_in   (data_in),
      .data_out  (data_out),
      .rd_valid  (rd_valid),
      .addr_err  (addr_err),
      .wr_blocked(wr_blocked),
      .dump_start(dump_start),
      .dump_busy (dump_busy),
      .dump_valid(dump_valid),
      .dump_ready(dump_ready),
      .dump_data (dump_data),
      .dump_index(dump_index),
      .dump_done (dump_done)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the design wedges the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] time limit exceeded");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   // Model contents after reset, straight from the memory's reset rules.
   function automatic void resetModel();
      for (int i = 0; i < int'(N); i++) begin
         ref_a[i] = 32'(i + 1);
         ref_b[i] = ((i % (DIM + 1)) == 0) ? 32'd1 : 32'd0;
         ref_c[i] = 32'd0;
      end
      ref_last = 32'd0;
      ref_busy = 1'b0;
      ref_left = 0;
      done_due = 1'b0;
      cpu_q.delete();
      dump_q.delete();
   endfunction

   // Region: 0 none, 1 A, 2 B, 3 C.
   function automatic void decode(input logic [31:0] addr, output int region, output int idx);
      region = 0;
      idx    = 0;
      if (addr % 4 == 0) begin
         if (addr >= A_BASE && addr < A_BASE + 4 * N) begin
            region = 1;
            idx    = int'((addr - A_BASE) / 4);
         end else if (addr >= B_BASE && addr < B_BASE + 4 * N) begin
            region = 2;
            idx    = int'((addr - B_BASE) / 4);
         end else if (addr >= C_BASE && addr < C_BASE + 4 * N) begin
            region = 3;
            idx    = int'((addr - C_BASE) / 4);
         end
      end
   endfunction

   function automatic logic [31:0] readRef(input int region, input int idx);
      case (region)
         1:       return ref_a[idx];
         2:       return ref_b[idx];
         3:       return ref_c[idx];
         default: return 32'd0;
      endcase
   endfunction

   // Drive one cycle of inputs, predict its effect, and advance one clock.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] din, input logic start, input logic ready);
      int       region;
      int       idx;
      cpu_exp_t e;
      mem_read   = rd;
      mem_write  = wr;
      address    = addr;
      data_in    = din;
      dump_start = start;
      dump_ready = ready;
      checkOutput("dump_busy", 64'(dump_busy), 64'(ref_busy));
      checkOutput("dump_valid", 64'(dump_valid), 64'(ref_busy));
      decode(addr, region, idx);
      if (rd && wr) begin
         e = '{rv: 1'b0, ae: 1'b1, wb: 1'b0, data: ref_last};
         cpu_q.push_back(e);
      end else if (rd) begin
         ref_last = readRef(region, idx);
         e = '{rv: 1'b1, ae: (region == 0), wb: 1'b0, data: ref_last};
         cpu_q.push_back(e);
      end else if (wr) begin
         if (region == 0) begin
            e = '{rv: 1'b0, ae: 1'b1, wb: 1'b0, data: ref_last};
            cpu_q.push_back(e);
         end else if (region == 3 && ref_busy) begin
            e = '{rv: 1'b0, ae: 1'b0, wb: 1'b1, data: ref_last};
            cpu_q.push_back(e);
         end else if (region == 1) begin
            ref_a[idx] = din;
         end else if (region == 2) begin
            ref_b[idx] = din;
         end else begin
            ref_c[idx] = din;
         end
      end
      if (ref_busy) begin
         if (ready) begin
            ref_left--;
            if (ref_left == 0) ref_busy = 1'b0;
         end
      end else if (start) begin
         ref_busy = 1'b1;
         ref_left = N;
         for (int k = 0; k < int'(N); k++) begin
            dump_q.push_back('{idx: k, data: ref_c[k]});
         end
      end
      @(posedge clk);
      #2;
   endtask

   task automatic idleInputs();
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      address    = '0;
      data_in    = '0;
      dump_start = 1'b0;
      dump_ready = 1'b0;
   endtask

   // Assert reset away from the clock, check it takes effect immediately.
   task automatic doReset();
      rst_n = 1'b0;
      idleInputs();
      #1;
      checkOutput("rst_dump_busy", 64'(dump_busy), 64'd0);
      checkOutput("rst_dump_valid", 64'(dump_valid), 64'd0);
      checkOutput("rst_dump_index", 64'(dump_index), 64'd0);
      resetModel();
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] pickAddr();
      int k;
      int sel;
      k   = $urandom_range(0, N - 1);
      sel = $urandom_range(0, 5);
      case (sel)
         0:       return A_BASE + 32'(4 * k);
         1:       return B_BASE + 32'(4 * k);
         3:       return C_BASE + 32'(4 * k) + 32'($urandom_range(1, 3));
         4: begin
            case ($urandom_range(0, 3))
               0:       return C_BASE + 32'(4 * N);
               1:       return A_BASE - 32'd4;
               2:       return B_BASE + 32'(4 * N);
               default: return 32'd0;
            endcase
         end
         default: return C_BASE + 32'(4 * k);
      endcase
   endfunction

   // Monitor: compares CPU pulses and accepted dump words against the queues.
   cpu_exp_t  mon_e;
   dump_exp_t mon_d;

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (dump_done || done_due) begin
               checkOutput("dump_done", 64'(dump_done), 64'(done_due));
            end
            done_due = 1'b0;
            if (rd_valid || addr_err || wr_blocked) begin
               if (cpu_q.size() == 0) begin
                  checkOutput("cpu_unexpected", 64'({rd_valid, addr_err, wr_blocked}), 64'd0);
               end else begin
                  mon_e = cpu_q.pop_front();
                  checkOutput("rd_valid", 64'(rd_valid), 64'(mon_e.rv));
                  checkOutput("addr_err", 64'(addr_err), 64'(mon_e.ae));
                  checkOutput("wr_blocked", 64'(wr_blocked), 64'(mon_e.wb));
                  checkOutput("data_out", 64'(data_out), 64'(mon_e.data));
               end
            end
            if (dump_valid && dump_ready) begin
               if (dump_q.size() == 0) begin
                  checkOutput("dump_unexpected", 64'(dump_valid), 64'd0);
               end else begin
                  mon_d = dump_q.pop_front();
                  checkOutput("dump_index", 64'(dump_index), 64'(mon_d.idx));
                  checkOutput("dump_data", 64'(dump_data), 64'(mon_d.data));
                  if (mon_d.idx == int'(N) - 1) done_due = 1'b1;
               end
            end
         end
      end
   end

   // Driver: directed scenarios, then randomized traffic, then mid-dump reset.
   initial begin
      int cyc;
      logic [31:0] plan_addr [4];
      rst_n = 1'b0;
      idleInputs();
      resetModel();
      repeat (2) @(posedge clk);
      #2;
      checkOutput("reset_data_out", 64'(data_out), 64'd0);
      checkOutput("reset_pulses", 64'({rd_valid, addr_err, wr_blocked, dump_done}), 64'd0);
      checkOutput("reset_dump_busy", 64'(dump_busy), 64'd0);
      checkOutput("reset_dump_index", 64'(dump_index), 64'd0);
      rst_n = 1'b1;

      // Reset contents of A and B.
      plan_addr = '{32'h200, 32'h220, 32'h304, 32'h320};
      foreach (plan_addr[i]) applyStimulus(1, 0, plan_addr[i], 0, 0, 0);

      // Store then immediately load back.
      applyStimulus(0, 1, 32'h100, 32'hAAAA_0001, 0, 0);
      applyStimulus(0, 1, 32'h120, 32'd7, 0, 0);
      applyStimulus(1, 0, 32'h100, 0, 0, 0);
      applyStimulus(1, 0, 32'h120, 0, 0, 0);

      // Misaligned, unmapped, both strobes, then confirm memory untouched.
      applyStimulus(1, 0, 32'h202, 0, 0, 0);
      applyStimulus(1, 0, 32'h124, 0, 0, 0);
      applyStimulus(1, 1, 32'h200, 32'hDEAD_BEEF, 0, 0);
      applyStimulus(0, 1, 32'h124, 32'h1234, 0, 0);
      applyStimulus(1, 0, 32'h200, 0, 0, 0);

      // Fill C with 10..18 and stream it at full rate.
      for (int k = 0; k < int'(N); k++) begin
         applyStimulus(0, 1, C_BASE + 32'(4 * k), 32'(10 + k), 0, 0);
      end
      applyStimulus(0, 0, 0, 0, 1, 1);
      repeat (N) applyStimulus(0, 0, 0, 0, 0, 1);

      // Start again in the dump_done cycle; stream with ready 1,0,0,1,...
      applyStimulus(0, 0, 0, 0, 1, 1);
      cyc = 0;
      while (ref_busy && cyc < 40) begin
         case (cyc)
            1:       applyStimulus(0, 1, 32'h104, 32'd99, 0, (cyc % 4 == 0) || (cyc % 4 == 3));
            2:       applyStimulus(0, 1, 32'h200, 32'd5, 1, (cyc % 4 == 0) || (cyc % 4 == 3));
            3:       applyStimulus(1, 0, 32'h104, 0, 0, (cyc % 4 == 0) || (cyc % 4 == 3));
            4:       applyStimulus(1, 0, 32'h200, 0, 0, (cyc % 4 == 0) || (cyc % 4 == 3));
            default: applyStimulus(0, 0, 0, 0, 0, (cyc % 4 == 0) || (cyc % 4 == 3));
         endcase
         cyc++;
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 32'h104, 0, 0, 0);

      // Randomized mix of loads, stores, errors and dumps.
      for (int t = 0; t < 500; t++) begin
         int op;
         op = $urandom_range(0, 9);
         applyStimulus(op <= 3 || op == 7, (op >= 4 && op <= 7), pickAddr(), $urandom,
                       ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0));
      end

      // Drain, then abort a dump with reset and confirm reset contents.
      cyc = 0;
      while (ref_busy && cyc < 40) begin
         applyStimulus(0, 0, 0, 0, 0, 1);
         cyc++;
      end
      applyStimulus(0, 1, 32'h200, 32'd5, 0, 0);
      applyStimulus(0, 1, 32'h108, 32'd42, 1, 1);
      repeat (3) applyStimulus(0, 0, 0, 0, 0, 1);
      doReset();
      for (int k = 0; k < int'(N); k++) begin
         applyStimulus(1, 0, C_BASE + 32'(4 * k), 0, 0, 0);
      end
      applyStimulus(1, 0, 32'h200, 0, 0, 0);
      repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);

      checkOutput("cpu_queue_left", 64'(cpu_q.size()), 64'd0);
      checkOutput("dump_queue_left", 64'(dump_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
